// File: rtl/pmem_responder.sv
// rtl/pmem_responder.sv - fixed-latency 128-bit block memory responder for the pmem interface
module pmem_responder #(
    parameter int LATENCY    = 10,
    parameter int DEPTH_BITS = 12
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         pmem_read,
    input  logic         pmem_write,
    input  logic [15:0]  pmem_address,
    input  logic [127:0] pmem_wdata,
    output logic [127:0] pmem_rdata,
    output logic         pmem_resp,
    output logic         proto_err
);

    typedef logic [127:0] lc3b_block;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [7:0] COUNT_LOAD = 8'(LATENCY - 2);

    state_t                  state;
    logic [7:0]              count;
    logic [DEPTH_BITS-1:0]   idx;
    lc3b_block               wdata_q;
    logic                    op_write;

    lc3b_block mem [0:(2**DEPTH_BITS)-1];

    // Offset bits and any index bits above the array size are intentionally dropped.
    logic unused_addr;
    assign unused_addr = &{1'b0, pmem_address};

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            count      <= 8'd0;
            idx        <= '0;
            wdata_q    <= '0;
            op_write   <= 1'b0;
            pmem_resp  <= 1'b0;
            pmem_rdata <= '0;
            proto_err  <= 1'b0;
        end else begin
            pmem_resp <= 1'b0;
            case (state)
                IDLE: begin
                    if (pmem_read || pmem_write) begin
                        idx      <= pmem_address[DEPTH_BITS+3:4];
                        wdata_q  <= pmem_wdata;
                        op_write <= pmem_write;
                        count    <= COUNT_LOAD;
                        if (pmem_read && pmem_write) begin
                            proto_err <= 1'b1;
                        end
                        state    <= BUSY;
                    end
                end
                BUSY: begin
                    // Response is registered one cycle early so it is visible during RESP.
                    if (count == 8'd0) begin
                        state     <= RESP;
                        pmem_resp <= 1'b1;
                        if (!op_write) begin
                            pmem_rdata <= mem[idx];
                        end
                    end else begin
                        count <= count - 8'd1;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // A reset landing on the RESP cycle aborts the write as well.
    always_ff @(posedge clk) begin
        if (reset && (state == RESP) && op_write) begin
            mem[idx] <= wdata_q;
        end
    end

endmodule

// File: tb/tb_pmem_responder.sv
// tb/tb_pmem_responder.sv - directed self-checking bench for pmem_responder
module tb_pmem_responder;

    logic         clk;
    logic         reset;
    logic         pmem_read;
    logic         pmem_write;
    logic [15:0]  pmem_address;
    logic [127:0] pmem_wdata;
    logic [127:0] pmem_rdata;
    logic         pmem_resp;
    logic         proto_err;

    int pass_cnt = 0;
    int total_cnt = 0;

    int           rc[$];
    logic [127:0] rd[$];
    logic         pe1;
    logic         post_resp;
    logic [127:0] post_rdata;
    logic         post_pe;

    localparam logic [127:0] D_BASIC = 128'h0000_0000_0000_0000_0000_0000_0011_2233;
    localparam logic [127:0] D_BEEF  = 128'hDEAD_BEEF_DEAD_BEEF_DEAD_BEEF_DEAD_BEEF;
    localparam logic [127:0] D_A     = 128'hAAAA_0001_AAAA_0002_AAAA_0003_AAAA_0004;
    localparam logic [127:0] D_B     = 128'hBBBB_0001_BBBB_0002_BBBB_0003_BBBB_0004;
    localparam logic [127:0] D_C     = 128'hCCCC_0001_CCCC_0002_CCCC_0003_CCCC_0004;
    localparam logic [127:0] D_D     = 128'h1234_5678_9ABC_DEF0_0FED_CBA9_8765_4321;
    localparam logic [127:0] D_P     = 128'h5555_6666_7777_8888_9999_AAAA_BBBB_CCCC;
    localparam logic [127:0] D_Q     = 128'hFFFF_EEEE_DDDD_CCCC_BBBB_AAAA_9999_8888;

    pmem_responder #(
        .LATENCY    (10),
        .DEPTH_BITS (12)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .pmem_read    (pmem_read),
        .pmem_write   (pmem_write),
        .pmem_address (pmem_address),
        .pmem_wdata   (pmem_wdata),
        .pmem_rdata   (pmem_rdata),
        .pmem_resp    (pmem_resp),
        .proto_err    (proto_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total_cnt++;
        if (got === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Called at a negedge with the request already driven; the next posedge is cycle 0.
    // mode 0: drop request on resp; 1: hold request; 2: on first resp switch to a read of chg_addr,
    // drop on second resp.
    task automatic watch(input int ncyc, input int mode, input int chg_cyc,
                         input logic [15:0] chg_addr, input logic [127:0] chg_data,
                         input int drop_cyc, input int rst_cyc);
        rc.delete();
        rd.delete();
        @(posedge clk);
        for (int n = 1; n <= ncyc; n++) begin
            @(negedge clk);
            if (n == 1) pe1 = proto_err;
            if (rst_cyc > 0 && n == rst_cyc + 1) begin
                post_resp  = pmem_resp;
                post_rdata = pmem_rdata;
                post_pe    = proto_err;
            end
            if (pmem_resp) begin
                rc.push_back(n);
                rd.push_back(pmem_rdata);
                if (mode == 0 || (mode == 2 && rc.size() == 2)) begin
                    pmem_read  = 1'b0;
                    pmem_write = 1'b0;
                end else if (mode == 2) begin
                    pmem_write   = 1'b0;
                    pmem_read    = 1'b1;
                    pmem_address = chg_addr;
                end
            end
            if (n == chg_cyc) begin
                pmem_address = chg_addr;
                pmem_wdata   = chg_data;
            end
            if (n == drop_cyc) begin
                pmem_read  = 1'b0;
                pmem_write = 1'b0;
            end
            if (rst_cyc > 0 && n == rst_cyc) begin
                reset      = 1'b0;
                pmem_read  = 1'b0;
                pmem_write = 1'b0;
            end
            if (rst_cyc > 0 && n == rst_cyc + 2) reset = 1'b1;
        end
    endtask

    task automatic txn(input logic rdq, input logic wrq, input logic [15:0] addr,
                       input logic [127:0] data);
        pmem_read    = rdq;
        pmem_write   = wrq;
        pmem_address = addr;
        pmem_wdata   = data;
        watch(20, 0, -1, 16'h0, '0, -1, -1);
    endtask

    initial begin
        reset        = 1'b0;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = '0;
        pmem_wdata   = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_resp", pmem_resp, 0);
        check("rst_rdata", pmem_rdata, 0);
        check("rst_proto_err", proto_err, 0);
        reset = 1'b1;
        @(negedge clk);

        // basic read
        txn(1'b0, 1'b1, 16'h0120, D_BASIC);
        check("wr_basic_resp_cyc", rc[0], 10);
        txn(1'b1, 1'b0, 16'h0120, '0);
        check("rd_basic_npulse", rc.size(), 1);
        check("rd_basic_resp_cyc", rc[0], 10);
        check("rd_basic_data", rd[0], D_BASIC);

        // write then read with different offset bits, back to back
        pmem_read    = 1'b0;
        pmem_write   = 1'b1;
        pmem_address = 16'h3A40;
        pmem_wdata   = D_BEEF;
        watch(30, 2, -1, 16'h3A4F, '0, -1, -1);
        check("wr_rd_npulse", rc.size(), 2);
        check("wr_rd_first_cyc", rc[0], 10);
        check("wr_rd_spacing", rc[1] - rc[0], 11);
        check("wr_rd_data", rd[1], D_BEEF);

        // held request
        pmem_read    = 1'b1;
        pmem_write   = 1'b0;
        pmem_address = 16'h0120;
        watch(40, 1, -1, 16'h0, '0, -1, -1);
        check("held_npulse", rc.size(), 3);
        check("held_p0", rc[0], 10);
        check("held_p1", rc[1], 21);
        check("held_p2", rc[2], 32);
        check("held_data", rd[2], D_BASIC);
        pmem_read = 1'b0;
        repeat (15) @(negedge clk);

        // mid-transaction changes
        txn(1'b0, 1'b1, 16'h0600, D_C);
        pmem_read    = 1'b0;
        pmem_write   = 1'b1;
        pmem_address = 16'h0500;
        pmem_wdata   = D_A;
        watch(20, 0, 2, 16'h0600, D_B, 3, -1);
        check("mid_npulse", rc.size(), 1);
        check("mid_resp_cyc", rc[0], 10);
        txn(1'b1, 1'b0, 16'h0500, '0);
        check("mid_orig_addr_data", rd[0], D_A);
        txn(1'b1, 1'b0, 16'h0600, '0);
        check("mid_other_untouched", rd[0], D_C);

        // read and write together
        check("rw_pe_before", proto_err, 0);
        txn(1'b1, 1'b1, 16'h0040, D_D);
        check("rw_pe_cyc1", pe1, 1);
        check("rw_resp_cyc", rc[0], 10);
        txn(1'b1, 1'b0, 16'h0040, '0);
        check("rw_write_done", rd[0], D_D);
        check("rw_pe_sticky", proto_err, 1);

        // reset mid-transaction
        txn(1'b0, 1'b1, 16'h0080, D_P);
        pmem_read    = 1'b0;
        pmem_write   = 1'b1;
        pmem_address = 16'h0080;
        pmem_wdata   = D_Q;
        watch(25, 0, -1, 16'h0, '0, -1, 5);
        check("rstmid_npulse", rc.size(), 0);
        check("rstmid_resp", post_resp, 0);
        check("rstmid_rdata", post_rdata, 0);
        check("rstmid_pe", post_pe, 0);
        txn(1'b1, 1'b0, 16'h0080, '0);
        check("rstmid_resp_cyc", rc[0], 10);
        check("rstmid_prior_data", rd[0], D_P);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
